// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared state encoding and default widths for the count monitor.
`default_nettype none

package count_monitor_pkg;

   typedef enum logic [1:0] {
      ST_UNSYNC  = 2'd0,
      ST_SYNCING = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam int unsigned WIDTH_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/count_monitor_event_counter.sv
// event_counter: event counter with synchronous clear; wraps or saturates at all-ones.
`default_nettype none

module event_counter #(
   parameter int unsigned WIDTH = 8,
   parameter bit          SAT   = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] value_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         if (SAT && (&cnt_q)) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/count_monitor.sv
// count_monitor: checks that an upstream count advances by +1 per valid sample,
// reports lock, wrap-arounds and sequence errors.
`default_nettype none

module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] count_in_i,
   output logic             locked_o,
   output logic             wrap_pulse_o,
   output logic             err_pulse_o,
   output logic [CNT_W-1:0] wrap_count_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [WIDTH-1:0] last_count_o
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [3:0]       run_q, run_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             wrap_pulse_q, wrap_pulse_d;
   logic             err_pulse_q, err_pulse_d;
   logic             wrap_inc;
   logic             err_inc;
   logic             good;

   assign good = in_valid_i && (count_in_i == expected_q);

   always_comb begin
      state_d      = state_q;
      expected_d   = expected_q;
      run_d        = run_q;
      last_d       = last_q;
      wrap_pulse_d = 1'b0;
      err_pulse_d  = 1'b0;
      wrap_inc     = 1'b0;
      err_inc      = 1'b0;
      if (clear_i) begin
         state_d    = ST_UNSYNC;
         expected_d = '0;
         run_d      = '0;
         last_d     = '0;
      end else if (in_valid_i) begin
         // Every accepted sample re-seeds the prediction, good or bad.
         expected_d = count_in_i + WIDTH'(1);
         last_d     = count_in_i;
         case (state_q)
            ST_UNSYNC: begin
               run_d   = '0;
               state_d = ST_SYNCING;
            end
            ST_SYNCING: begin
               if (good) begin
                  run_d = run_q + 4'd1;
                  if ((run_q + 4'd1) == 4'(LOCK_CNT)) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  run_d = '0;
               end
            end
            ST_LOCKED: begin
               if (good) begin
                  if (count_in_i == '0) begin
                     wrap_pulse_d = 1'b1;
                     wrap_inc     = 1'b1;
                  end
               end else begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  run_d       = '0;
                  state_d     = ST_SYNCING;
               end
            end
            default: begin
               state_d = ST_UNSYNC;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_UNSYNC;
         expected_q   <= '0;
         run_q        <= '0;
         last_q       <= '0;
         wrap_pulse_q <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         expected_q   <= expected_d;
         run_q        <= run_d;
         last_q       <= last_d;
         wrap_pulse_q <= wrap_pulse_d;
         err_pulse_q  <= err_pulse_d;
      end
   end

   event_counter #(
      .WIDTH (CNT_W),
      .SAT   (1'b0)
   ) u_wrap_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .inc_i   (wrap_inc),
      .value_o (wrap_count_o)
   );

   event_counter #(
      .WIDTH (CNT_W),
      .SAT   (1'b1)
   ) u_err_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .inc_i   (err_inc),
      .value_o (err_count_o)
   );

   assign locked_o     = (state_q == ST_LOCKED);
   assign wrap_pulse_o = wrap_pulse_q;
   assign err_pulse_o  = err_pulse_q;
   assign last_count_o = last_q;

endmodule

`default_nettype wire

// File: tb/tb_count_monitor.sv
// tb_count_monitor: randomized self-checking bench against a sequence-level reference model.
`default_nettype none

module tb_count_monitor;

   localparam int LOCK_CNT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic       locked;
   logic       wrap_pulse;
   logic       err_pulse;
   logic [7:0] wrap_count;
   logic [7:0] err_count;
   logic [3:0] last_count;

   int checks = 0;
   int errors = 0;

   // Reference model: tracks the previous sample and the length of the current correct run.
   bit m_have;
   int m_prev;
   int m_streak;
   bit m_locked;
   bit m_wp;
   bit m_ep;
   int m_wrap;
   int m_err;
   int m_last;

   count_monitor #(
      .WIDTH    (4),
      .LOCK_CNT (LOCK_CNT),
      .CNT_W    (8)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .in_valid_i   (in_valid),
      .count_in_i   (count_in),
      .locked_o     (locked),
      .wrap_pulse_o (wrap_pulse),
      .err_pulse_o  (err_pulse),
      .wrap_count_o (wrap_count),
      .err_count_o  (err_count),
      .last_count_o (last_count)
   );

   always #5 clk = ~clk;

   wire [22:0] act = {locked, wrap_pulse, err_pulse, wrap_count, err_count, last_count};

   function automatic logic [22:0] exp_vec();
      return {m_locked, m_wp, m_ep, 8'(m_wrap), 8'(m_err), 4'(m_last)};
   endfunction

   task automatic model_reset();
      m_have = 0; m_prev = 0; m_streak = 0; m_locked = 0;
      m_wp = 0; m_ep = 0; m_wrap = 0; m_err = 0; m_last = 0;
   endtask

   task automatic step(input bit v, input logic [3:0] x, input bit clr);
      @(negedge clk);
      in_valid = v;
      count_in = x;
      clear    = clr;
      @(posedge clk);
      m_wp = 0;
      m_ep = 0;
      if (clr) begin
         model_reset();
      end else if (v) begin
         if (!m_have) begin
            m_have = 1; m_streak = 0; m_locked = 0;
         end else if (int'(x) == (m_prev + 1) % 16) begin
            if (m_locked && x == 4'd0) begin
               m_wp = 1;
               m_wrap = (m_wrap + 1) % 256;
            end
            m_streak++;
            if (m_streak >= LOCK_CNT) m_locked = 1;
         end else begin
            if (m_locked) begin
               m_ep = 1;
               if (m_err < 255) m_err++;
            end
            m_locked = 0;
            m_streak = 0;
         end
         m_prev = int'(x);
         m_last = int'(x);
      end
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (act !== 23'd0) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", act, 23'd0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lock();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'(i), 1'b0);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL lock step %0d: got %h want %h", i, act, exp_vec());
         end
      end
      checks++;
      if (locked !== 1'b1 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL lock_after_4: got locked=%b err=%0d want locked=1 err=0", locked, err_count);
      end
   endtask

   task automatic test_wrap();
      int wraps_seen = 0;
      int errs_seen = 0;
      // Continue from 3: 4..15, then 0..15, 0..15, 0 gives three max->0 crossings.
      for (int i = 4; i < 16 + 16 + 16 + 1; i++) begin
         step(1'b1, 4'(i % 16), 1'b0);
         wraps_seen += int'(wrap_pulse);
         errs_seen  += int'(err_pulse);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL wrap step %0d: got %h want %h", i, act, exp_vec());
         end
      end
      checks++;
      if (wraps_seen != 3 || errs_seen != 0 || wrap_count !== 8'd3) begin
         errors++;
         $display("FAIL wrap_totals: got wraps=%0d errs=%0d cnt=%0d want 3 0 3", wraps_seen, errs_seen, wrap_count);
      end
   endtask

   task automatic test_error();
      logic [3:0] seq [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
      int e0;
      foreach (seq[i]) step(1'b1, seq[i], 1'b0);
      e0 = m_err;
      checks++;
      if (act !== exp_vec() || err_pulse !== 1'b1 || locked !== 1'b0) begin
         errors++;
         $display("FAIL error_jump: got %h want %h", act, exp_vec());
      end
      for (int i = 8; i <= 10; i++) begin
         step(1'b1, 4'(i), 1'b0);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL relock step %0d: got %h want %h", i, act, exp_vec());
         end
      end
      checks++;
      if (locked !== 1'b1 || err_count !== 8'(e0) || err_pulse !== 1'b0) begin
         errors++;
         $display("FAIL relock_done: got locked=%b err=%0d want locked=1 err=%0d", locked, err_count, e0);
      end
   endtask

   task automatic test_gaps();
      step(1'b1, 4'd11, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL gap cycle %0d: got %h want %h", i, act, exp_vec());
         end
      end
      step(1'b1, 4'd12, 1'b0);
      checks++;
      if (act !== exp_vec() || locked !== 1'b1 || err_pulse !== 1'b0) begin
         errors++;
         $display("FAIL gap_resume: got %h want %h", act, exp_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         int r = $urandom_range(0, 99);
         logic [3:0] nxt = 4'((m_prev + 1) % 16);
         if (r < 2)       step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
         else if (r < 15) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
         else if (r < 25) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
         else             step(1'b1, nxt, 1'b0);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL random step %0d: got %h want %h", i, act, exp_vec());
         end
      end
   endtask

   task automatic test_wrap_rollover();
      int start;
      for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0);
      start = m_wrap;
      for (int i = 4; i < 16 * 260; i++) begin
         step(1'b1, 4'(i % 16), 1'b0);
         checks++;
         if (act !== exp_vec()) begin
            errors++;
            $display("FAIL rollover step %0d: got %h want %h", i, act, exp_vec());
         end
      end
      checks++;
      if (wrap_count !== 8'((start + 259) % 256)) begin
         errors++;
         $display("FAIL wrap_rollover: got %0d want %0d", wrap_count, (start + 259) % 256);
      end
   endtask

   task automatic test_saturation();
      int p;
      for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0);
      for (int k = 0; k < 260; k++) begin
         p = (m_prev + 2 + int'($urandom_range(0, 12))) % 16;
         step(1'b1, 4'(p), 1'b0);
         checks++;
         if (act !== exp_vec() || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL saturate err %0d: got %h want %h", k, act, exp_vec());
         end
         for (int j = 1; j <= 3; j++) step(1'b1, 4'((p + j) % 16), 1'b0);
      end
      checks++;
      if (err_count !== 8'd255 || locked !== 1'b1) begin
         errors++;
         $display("FAIL saturate_final: got err=%0d locked=%b want err=255 locked=1", err_count, locked);
      end
   endtask

   task automatic test_clear_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 6), 1'b0);
      step(1'b1, 4'd10, 1'b1);
      checks++;
      if (act !== 23'd0 || act !== exp_vec()) begin
         errors++;
         $display("FAIL clear_with_valid: got %h want %h", act, 23'd0);
      end
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (act !== 23'd0) begin
         errors++;
         $display("FAIL async_reset: got %h want %h", act, 23'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'(i + 9), 1'b0);
         checks++;
         if (act !== exp_vec() || locked !== (i == 3)) begin
            errors++;
            $display("FAIL post_reset_lock %0d: got %h want %h", i, act, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_wrap();
      test_error();
      test_gaps();
      test_random();
      test_wrap_rollover();
      test_saturation();
      test_clear_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
